// File: rtl/sap1_pkg.sv
// Shared constants and state encoding for the SAP-1 memory address register
// and RAM programming block.
package sap1_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int RAM_LINES = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_e;

endpackage

// File: rtl/sap1_mar_prog.sv
// SAP-1 memory address register with a byte-stream RAM programmer: run mode lets
// the controller address RAM through the MAR, program mode writes 16 lines in order.
module sap1_mar_prog
    import sap1_pkg::*;
(
    input  logic              clk,
    input  logic              n_clr,
    input  logic              prog,
    input  logic              n_lm,
    input  logic [DATA_W-1:0] w,
    input  logic              n_ce_run,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_d_oe,
    output logic              ram_n_we,
    output logic              ram_n_ce,
    output logic              prog_busy,
    output logic              prog_done
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              run_mode_s;
    logic              unused_w_s;

    assign run_mode_s = (state_q == IDLE) && !prog;
    assign unused_w_s = ^w[DATA_W-1:ADDR_W];
    assign prog_done  = done_q;

    // MAR next value: loads only in run mode, holds otherwise
    always_comb begin
        mar_d = mar_q;
        if (run_mode_s && !n_lm) begin
            mar_d = w[ADDR_W-1:0];
        end else begin
            mar_d = mar_q;
        end
    end

    // MAR register
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            mar_q <= {ADDR_W{1'b0}};
        end else begin
            mar_q <= mar_d;
        end
    end

    // Write FSM next state, pointer, data latch and done flag
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (prog) begin
                    if (din_valid) begin
                        data_d  = din;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    // Holding these clear in run mode realises the prog 1->0 reset.
                    ptr_d  = {ADDR_W{1'b0}};
                    done_d = 1'b0;
                end
            end
            SETUP:  state_d = STROBE;
            STROBE: state_d = HOLD;
            HOLD: begin
                state_d = IDLE;
                ptr_d   = ptr_q + ADDR_W'(1);
                if (ptr_q == ADDR_W'(RAM_LINES - 1)) begin
                    done_d = 1'b1;
                end else begin
                    done_d = done_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write FSM registers
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            state_q <= IDLE;
            ptr_q   <= {ADDR_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // RAM interface decode; gated by n_clr so reset forces a safe bus at once
    always_comb begin
        ram_a     = {ADDR_W{1'b0}};
        ram_d     = {DATA_W{1'b0}};
        ram_d_oe  = 1'b0;
        ram_n_we  = 1'b1;
        ram_n_ce  = 1'b1;
        din_ready = 1'b0;
        prog_busy = 1'b0;
        if (!n_clr) begin
            ram_n_ce = 1'b1;
        end else begin
            ram_d = data_q;
            case (state_q)
                IDLE: begin
                    if (prog) begin
                        ram_a     = ptr_q;
                        din_ready = 1'b1;
                    end else begin
                        ram_a    = mar_q;
                        ram_n_ce = n_ce_run;
                    end
                end
                SETUP, HOLD: begin
                    ram_a     = ptr_q;
                    ram_d_oe  = 1'b1;
                    ram_n_ce  = 1'b0;
                    prog_busy = 1'b1;
                end
                STROBE: begin
                    ram_a     = ptr_q;
                    ram_d_oe  = 1'b1;
                    ram_n_ce  = 1'b0;
                    ram_n_we  = 1'b0;
                    prog_busy = 1'b1;
                end
                default: begin
                    ram_a = {ADDR_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sap1_mar_prog.sv
// Self-checking bench for sap1_mar_prog: behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sap1_mar_prog;

    logic       clk = 1'b0;
    logic       n_clr, prog, n_lm, n_ce_run, din_valid;
    logic [7:0] w, din;
    logic       din_ready, ram_d_oe, ram_n_we, ram_n_ce, prog_busy, prog_done;
    logic [3:0] ram_a;
    logic [7:0] ram_d;

    sap1_mar_prog dut (
        .clk(clk), .n_clr(n_clr), .prog(prog), .n_lm(n_lm), .w(w),
        .n_ce_run(n_ce_run), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .ram_a(ram_a), .ram_d(ram_d), .ram_d_oe(ram_d_oe),
        .ram_n_we(ram_n_we), .ram_n_ce(ram_n_ce), .prog_busy(prog_busy),
        .prog_done(prog_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: cycles since acceptance (0 = idle), MAR, pointer, latched byte, done.
    int m_phase, m_mar, m_ptr, m_data, m_done;
    logic [11:0] strobe_log[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_mar = 0; m_ptr = 0; m_data = 0; m_done = 0;
    endtask

    task automatic model_update(output bit acc);
        acc = 1'b0;
        if (!n_clr) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (prog) begin
                if (din_valid) begin
                    m_data  = din;
                    m_phase = 1;
                    acc     = 1'b1;
                end
            end else begin
                if (!n_lm) m_mar = w & 8'h0F;
                m_ptr  = 0;
                m_done = 0;
            end
        end else if (m_phase == 3) begin
            if (m_ptr == 15) m_done = 1;
            m_ptr   = (m_ptr + 1) % 16;
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
        end
    endtask

    task automatic check_outputs();
        chk("prog_done", prog_done, m_done);
        if (!n_clr) begin
            chk("rst_we", ram_n_we, 1); chk("rst_oe", ram_d_oe, 0);
            chk("rst_ce", ram_n_ce, 1); chk("rst_ready", din_ready, 0);
            chk("rst_busy", prog_busy, 0); chk("rst_a", ram_a, 0);
            chk("rst_d", ram_d, 0);
        end else if (m_phase != 0) begin
            chk("wr_a", ram_a, m_ptr); chk("wr_d", ram_d, m_data);
            chk("wr_oe", ram_d_oe, 1); chk("wr_ce", ram_n_ce, 0);
            chk("wr_we", ram_n_we, (m_phase == 2) ? 0 : 1);
            chk("wr_busy", prog_busy, 1); chk("wr_ready", din_ready, 0);
        end else if (prog) begin
            chk("pidle_ready", din_ready, 1); chk("pidle_busy", prog_busy, 0);
            chk("pidle_we", ram_n_we, 1); chk("pidle_oe", ram_d_oe, 0);
        end else begin
            chk("run_a", ram_a, m_mar); chk("run_ce", ram_n_ce, n_ce_run);
            chk("run_we", ram_n_we, 1); chk("run_oe", ram_d_oe, 0);
            chk("run_ready", din_ready, 0); chk("run_busy", prog_busy, 0);
        end
        if (ram_n_we === 1'b0) strobe_log.push_back({ram_a, ram_d});
    endtask

    task automatic step(output bit acc);
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update(acc);
        cyc++;
        #1;
    endtask

    task automatic steps(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic write_byte(input logic [7:0] b);
        bit a;
        int guard;
        a = 1'b0; guard = 0;
        din = b; din_valid = 1'b1;
        while (!a && guard < 20) begin
            step(a);
            guard++;
        end
        din_valid = 1'b0;
        if (!a) chk("accept_timeout", 0, 1);
        steps(3);
    endtask

    logic [7:0] bytes[16];
    int         acc_cyc[16];

    initial begin
        bit a;
        int idx, guard;
        logic [11:0] last;
        n_clr = 1'b0; prog = 1'b0; n_lm = 1'b1; n_ce_run = 1'b1;
        w = 8'h00; din = 8'h00; din_valid = 1'b0;
        model_reset();
        #1;
        steps(2);
        n_clr = 1'b1;
        steps(1);

        // Run mode: MAR load and hold, chip enable pass-through.
        w = 8'h2D; n_lm = 1'b0;
        step(a);
        n_lm = 1'b1; w = 8'h07;
        #1 chk("mar_load", ram_a, 4'hD);
        step(a);
        chk("mar_hold", ram_a, 4'hD);
        n_ce_run = 1'b0;
        #1 chk("run_ce_lit", ram_n_ce, 0);
        steps(1);
        n_ce_run = 1'b1;

        // Program 16 bytes with din_valid held high.
        bytes[0] = 8'h0D; bytes[1] = 8'h1E; bytes[2] = 8'hE0; bytes[3] = 8'hF0;
        for (int i = 4; i < 16; i++) bytes[i] = 8'($urandom);
        strobe_log.delete();
        prog = 1'b1; idx = 0; guard = 0;
        din = bytes[0]; din_valid = 1'b1;
        while (idx < 16 && guard < 200) begin
            step(a);
            guard++;
            if (a) begin
                acc_cyc[idx] = cyc;
                idx++;
                din = (idx < 16) ? bytes[idx] : 8'h00;
            end
        end
        if (idx < 16) chk("stream_timeout", idx, 16);
        din_valid = 1'b0;
        steps(3);
        chk("done_after16", prog_done, 1);
        chk("strobe_count", strobe_log.size(), 16);
        for (int i = 0; i < 16 && i < strobe_log.size(); i++) begin
            chk("strobe_addr", strobe_log[i][11:8], i);
            chk("strobe_data", strobe_log[i][7:0], bytes[i]);
        end
        for (int i = 1; i < 16; i++) chk("accept_gap", acc_cyc[i] - acc_cyc[i-1], 4);

        // 17th byte wraps to line 0, done stays set.
        write_byte(8'hAA);
        last = strobe_log[strobe_log.size()-1];
        chk("wrap_addr", last[11:8], 0);
        chk("wrap_data", last[7:0], 8'hAA);
        chk("done_sticky", prog_done, 1);

        // Drop prog during SETUP of line 5.
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
        din = 8'h55; din_valid = 1'b1; a = 1'b0; guard = 0;
        while (!a && guard < 20) begin
            step(a);
            guard++;
        end
        if (!a) chk("l5_timeout", 0, 1);
        prog = 1'b0; din_valid = 1'b0;
        steps(3);
        last = strobe_log[strobe_log.size()-1];
        chk("l5_addr", last[11:8], 5);
        chk("l5_data", last[7:0], 8'h55);
        steps(1);
        chk("l5_done_clr", prog_done, 0);
        chk("l5_ram_a_mar", ram_a, 4'hD);
        prog = 1'b1;
        write_byte(8'h66);
        last = strobe_log[strobe_log.size()-1];
        chk("ptr_reset_addr", last[11:8], 0);

        // Reset in the middle of STROBE.
        din = 8'h77; din_valid = 1'b1; a = 1'b0; guard = 0;
        while (!a && guard < 20) begin
            step(a);
            guard++;
        end
        din_valid = 1'b0;
        step(a);
        chk("in_strobe", ram_n_we, 0);
        #1 n_clr = 1'b0;
        model_reset();
        #1;
        chk("rst_strobe_we", ram_n_we, 1);
        chk("rst_strobe_oe", ram_d_oe, 0);
        chk("rst_strobe_ce", ram_n_ce, 1);
        chk("rst_strobe_busy", prog_busy, 0);
        steps(2);
        n_clr = 1'b1;
        steps(1);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) prog = ~prog;
            n_lm      = 1'($urandom);
            w         = 8'($urandom);
            n_ce_run  = 1'($urandom);
            din       = 8'($urandom);
            din_valid = 1'($urandom);
            step(a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sap1_mar_prog.md
SAP1_MAR_PROG -- requirements
Module: sap1_mar_prog

Interface
REQ-001 Parameter: ADDR_W, 4, RAM address width (16 lines).
REQ-002 Parameter: DATA_W, 8, RAM data width.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 n_clr  input  1  reset, asynchronous, active-low.
REQ-005 prog  input  1  1 = program mode (load RAM), 0 = run mode (MAR drives RAM).
REQ-006 n_lm  input  1  active-low MAR load from the controller (run mode only).
REQ-007 w  input  8  W bus; bits [3:0] are the MAR load value.
REQ-008 n_ce_run  input  1  active-low RAM enable from the controller (run mode).
REQ-009 din  input  8  program byte.
REQ-010 din_valid  input  1  program byte offered.
REQ-011 din_ready  output  1  program byte accepted when din_valid and din_ready are both 1 on a rising edge.
REQ-012 ram_a  output  4  RAM address.
REQ-013 ram_d  output  8  RAM write data.
REQ-014 ram_d_oe  output  1  1 = ram_d drives the RAM data bus.
REQ-015 ram_n_we  output  1  active-low RAM write strobe.
REQ-016 ram_n_ce  output  1  active-low RAM chip enable.
REQ-017 prog_busy  output  1  1 while a write cycle is in progress.
REQ-018 prog_done  output  1  sticky; 1 after all 16 lines are written.

Function
REQ-019 The FSM SHALL have the states IDLE, SETUP, STROBE and HOLD.
REQ-020 In run mode (IDLE with prog=0), when n_lm=0, the MAR SHALL load w[3:0] on the rising edge; otherwise it holds.
REQ-021 In run mode: ram_a=MAR, ram_n_ce=n_ce_run, ram_n_we=1, ram_d_oe=0, din_ready=0.
REQ-022 In IDLE with prog=1, din_ready SHALL be 1; an accepted byte is latched and the FSM moves IDLE->SETUP.
REQ-023 SETUP, STROBE and HOLD each SHALL last exactly one cycle; SETUP->STROBE->HOLD->IDLE; a write takes 4 cycles including acceptance, and at most one byte is accepted every 4 cycles.
REQ-024 SETUP: ram_a=write pointer, ram_d=latched byte, ram_d_oe=1, ram_n_ce=0, ram_n_we=1.
REQ-025 STROBE: as SETUP, but with ram_n_we=0.
REQ-026 HOLD: as SETUP (ram_n_we=1); the address and data stay stable one cycle after the strobe. On leaving HOLD, the pointer SHALL increment modulo 16.
REQ-027 prog_busy SHALL be 1 exactly in SETUP, STROBE and HOLD.
REQ-028 After the write at pointer 15 completes, prog_done SHALL be set and the pointer SHALL wrap to 0. Further bytes are still accepted and overwrite from line 0.
REQ-029 prog is sampled only in IDLE. A prog change during SETUP/STROBE/HOLD SHALL NOT abort the write; the mode change takes effect on return to IDLE.
REQ-030 A prog 1->0 transition in IDLE SHALL clear prog_done and reset the pointer to 0. The MAR is unaffected.
REQ-031 n_lm SHALL be ignored in program mode. din_valid SHALL be ignored in run mode and in non-IDLE states.
REQ-032 All outputs SHALL be registered or decoded from registered state only; there are no combinational paths from din or w to the outputs.

Reset
REQ-033 n_clr=0 SHALL immediately force: FSM=IDLE, MAR=0, pointer=0, data latch=0, prog_done=0.
REQ-034 While n_clr=0: ram_n_we=1, ram_d_oe=0, ram_n_ce=1, din_ready=0, prog_busy=0, ram_a=0, ram_d=0.
REQ-035 A reset asserted during STROBE SHALL abort the write at once, with no partial strobe beyond the reset assertion.
REQ-036 Reset is released synchronously: state updates resume on the first rising edge after n_clr=1.

Structure
REQ-037 ADDR_W, DATA_W, the state encoding (IDLE=0, SETUP=1, STROBE=2, HOLD=3) and RAM_LINES=16 SHALL live in the shared package sap1_pkg.
REQ-038 The block SHALL be a single module with no sub-modules. The MAR and the write FSM are separate always blocks in the same file.

Verification
REQ-039 Reset mid-STROBE: assert n_clr=0 -> ram_n_we=1, ram_d_oe=0, ram_n_ce=1 with no clock edge, and prog_busy=0.
REQ-040 Run mode: w=0x2D, n_lm=0, one edge -> ram_a=0xD; n_lm=1, w=0x07 -> ram_a stays 0xD; n_ce_run=0 -> ram_n_ce=0.
REQ-041 Program mode: stream 16 bytes 0x0D,0x1E,0xE0,0xF0,0x00.. -> 16 strobes at ram_a 0..15 with matching ram_d, each low for exactly one cycle, and prog_done=1 after the 16th HOLD.
REQ-042 Back-pressure: din_valid held at 1 continuously -> din_ready pulses 1 cycle in every 4 and the bytes are accepted in order.
REQ-043 prog dropped during SETUP of line 5 -> the line-5 write completes, then run mode; prog_done=0, pointer=0, and ram_a returns to the MAR value.
REQ-044 17th byte 0xAA after prog_done -> written at line 0, and prog_done stays 1.
